// File: rtl/mips_controller_pkg.sv
// Shared types and encodings for the multicycle MIPS control unit:
// state enum, opcode/funct constants, ALU codes and mux select encodings.
package mips_ctrl_pkg;

  typedef enum logic [3:0] {
    S_FETCH1  = 4'd0,
    S_FETCH2  = 4'd1,
    S_FETCH3  = 4'd2,
    S_FETCH4  = 4'd3,
    S_DECODE  = 4'd4,
    S_MEMADR  = 4'd5,
    S_LBRD    = 4'd6,
    S_LBWR    = 4'd7,
    S_SBWR    = 4'd8,
    S_RTYPEEX = 4'd9,
    S_RTYPEWR = 4'd10,
    S_BEQEX   = 4'd11,
    S_JEX     = 4'd12
  } state_e;

  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;

  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_SLT = 6'b101010;

  localparam logic [2:0] ALU_ADD   = 3'b010;
  localparam logic [2:0] ALU_SUB   = 3'b110;
  localparam logic [2:0] ALU_AND   = 3'b000;
  localparam logic [2:0] ALU_OR    = 3'b001;
  localparam logic [2:0] ALU_SLT   = 3'b111;
  localparam logic [2:0] ALU_UNDEF = 3'b101;

  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  localparam logic [1:0] SRCB_B    = 2'b00;
  localparam logic [1:0] SRCB_ONE  = 2'b01;
  localparam logic [1:0] SRCB_IMM  = 2'b10;
  localparam logic [1:0] SRCB_IMM2 = 2'b11;

  typedef struct packed {
    logic       memread;
    logic       memwrite;
    logic       alusrca;
    logic       memtoreg;
    logic       iord;
    logic       regwrite;
    logic       regdst;
    logic       pcwrite;
    logic       branch;
    logic [1:0] pcsource;
    logic [1:0] alusrcb;
    logic [3:0] irwrite;
    logic [1:0] aluop;
  } ctrl_t;

  // Moore output word for each state; unused encodings decode to all zeros.
  function automatic ctrl_t ctrl_decode(state_e s);
    ctrl_t c;
    c = '0;
    case (s)
      S_FETCH1, S_FETCH2, S_FETCH3, S_FETCH4: begin
        c.memread = 1'b1;
        c.alusrcb = SRCB_ONE;
        c.pcwrite = 1'b1;
        c.irwrite = 4'b0001 << s[1:0];
      end
      S_DECODE:  c.alusrcb = SRCB_IMM2;
      S_MEMADR:  begin c.alusrca = 1'b1; c.alusrcb = SRCB_IMM; end
      S_LBRD:    begin c.memread = 1'b1; c.iord = 1'b1; end
      S_LBWR:    begin c.regwrite = 1'b1; c.memtoreg = 1'b1; end
      S_SBWR:    begin c.memwrite = 1'b1; c.iord = 1'b1; end
      S_RTYPEEX: begin c.alusrca = 1'b1; c.aluop = ALUOP_FUNCT; end
      S_RTYPEWR: begin c.regdst = 1'b1; c.regwrite = 1'b1; end
      S_BEQEX: begin
        c.alusrca  = 1'b1;
        c.aluop    = ALUOP_SUB;
        c.branch   = 1'b1;
        c.pcsource = PCSRC_ALUOUT;
      end
      S_JEX:     begin c.pcwrite = 1'b1; c.pcsource = PCSRC_JUMP; end
      default:   c = '0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/mips_controller_if.sv
// Control bundle between the MIPS controller (master) and the datapath (slave).
interface mips_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       memread;
  logic       memwrite;
  logic       alusrca;
  logic       memtoreg;
  logic       iord;
  logic       pcen;
  logic       regwrite;
  logic       regdst;
  logic [1:0] pcsource;
  logic [1:0] alusrcb;
  logic [3:0] irwrite;
  logic [2:0] alucontrol;

  modport master (
    input  op, funct, zero,
    output memread, memwrite, alusrca, memtoreg, iord, pcen, regwrite,
           regdst, pcsource, alusrcb, irwrite, alucontrol
  );

  modport slave (
    output op, funct, zero,
    input  memread, memwrite, alusrca, memtoreg, iord, pcen, regwrite,
           regdst, pcsource, alusrcb, irwrite, alucontrol
  );
endinterface

// File: rtl/mips_controller_aludec.sv
// ALU decoder: maps aluop and the R-type funct field onto an ALU operation code.
module mips_aludec
  import mips_ctrl_pkg::*;
(
  input  logic [1:0] aluop_i,
  input  logic [5:0] funct_i,
  output logic [2:0] alucontrol_o
);

  always_comb begin
    alucontrol_o = ALU_ADD;
    case (aluop_i)
      ALUOP_SUB: alucontrol_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct_i)
          FN_ADD:  alucontrol_o = ALU_ADD;
          FN_SUB:  alucontrol_o = ALU_SUB;
          FN_AND:  alucontrol_o = ALU_AND;
          FN_OR:   alucontrol_o = ALU_OR;
          FN_SLT:  alucontrol_o = ALU_SLT;
          default: alucontrol_o = ALU_UNDEF;
        endcase
      end
      default: alucontrol_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/mips_controller.sv
// Multicycle MIPS control FSM: byte-wide fetch sequencing, opcode dispatch,
// Moore control word, PC enable and ALU decode.
module mips_controller
  import mips_ctrl_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  mips_controller_if.master bus
);

  state_e state_q, state_d;
  ctrl_t  ctrl;

  always_comb begin
    state_d = S_FETCH1;
    case (state_q)
      S_FETCH1:  state_d = S_FETCH2;
      S_FETCH2:  state_d = S_FETCH3;
      S_FETCH3:  state_d = S_FETCH4;
      S_FETCH4:  state_d = S_DECODE;
      S_DECODE: begin
        case (bus.op)
          OP_LB, OP_SB: state_d = S_MEMADR;
          OP_RTYPE:     state_d = S_RTYPEEX;
          OP_BEQ:       state_d = S_BEQEX;
          OP_J:         state_d = S_JEX;
          default:      state_d = S_FETCH1;
        endcase
      end
      S_MEMADR:  state_d = (bus.op == OP_LB) ? S_LBRD : S_SBWR;
      S_LBRD:    state_d = S_LBWR;
      S_RTYPEEX: state_d = S_RTYPEWR;
      default:   state_d = S_FETCH1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_FETCH1;
    else       state_q <= state_d;
  end

  assign ctrl = ctrl_decode(state_q);

  // Strobes that change architectural state are held off while reset is high.
  assign bus.memread  = ctrl.memread  & ~reset;
  assign bus.memwrite = ctrl.memwrite & ~reset;
  assign bus.regwrite = ctrl.regwrite & ~reset;
  assign bus.irwrite  = ctrl.irwrite  & {4{~reset}};
  assign bus.pcen     = ~reset & (ctrl.pcwrite | (ctrl.branch & bus.zero));

  assign bus.alusrca  = ctrl.alusrca;
  assign bus.memtoreg = ctrl.memtoreg;
  assign bus.iord     = ctrl.iord;
  assign bus.regdst   = ctrl.regdst;
  assign bus.pcsource = ctrl.pcsource;
  assign bus.alusrcb  = ctrl.alusrcb;

  mips_aludec u_aludec (
    .aluop_i      (ctrl.aluop),
    .funct_i      (bus.funct),
    .alucontrol_o (bus.alucontrol)
  );

endmodule

// File: tb/tb_mips_controller.sv
// Bench for mips_controller: per-instruction expected control sequences built
// from the instruction-level behaviour and compared cycle by cycle.
module tb_mips_controller;

  logic clk = 1'b0;
  logic reset = 1'b1;
  int   total = 0;
  int   bad = 0;

  mips_controller_if bus();

  mips_controller dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // {memread,memwrite,alusrca,memtoreg,iord,pcen,regwrite,regdst,pcsource,alusrcb,irwrite,alucontrol}
  logic [18:0] exp_q[$];

  function automatic logic [18:0] v(bit mr, bit mw, bit asa, bit m2r, bit io,
                                    bit pe, bit rw, bit rd, logic [1:0] ps,
                                    logic [1:0] sb, logic [3:0] ir, logic [2:0] alu);
    return {mr, mw, asa, m2r, io, pe, rw, rd, ps, sb, ir, alu};
  endfunction

  function automatic logic [18:0] obs();
    return {bus.memread, bus.memwrite, bus.alusrca, bus.memtoreg, bus.iord,
            bus.pcen, bus.regwrite, bus.regdst, bus.pcsource, bus.alusrcb,
            bus.irwrite, bus.alucontrol};
  endfunction

  function automatic logic [2:0] ref_alu(logic [5:0] f);
    if (f == 6'd32) return 3'd2;
    if (f == 6'd34) return 3'd6;
    if (f == 6'd36) return 3'd0;
    if (f == 6'd37) return 3'd1;
    if (f == 6'd42) return 3'd7;
    return 3'd5;
  endfunction

  // Expected per-cycle outputs for one instruction, starting at its first fetch.
  task automatic model(input logic [5:0] op, input logic [5:0] f, input bit z);
    logic [3:0] ir;
    exp_q.delete();
    for (int k = 0; k < 4; k++) begin
      ir = 4'd1 << k;
      exp_q.push_back(v(1,0,0,0,0,1,0,0, 2'd0, 2'd1, ir, 3'd2));
    end
    exp_q.push_back(v(0,0,0,0,0,0,0,0, 2'd0, 2'd3, 4'd0, 3'd2));
    if (op == 6'd32 || op == 6'd40)
      exp_q.push_back(v(0,0,1,0,0,0,0,0, 2'd0, 2'd2, 4'd0, 3'd2));
    if (op == 6'd32) begin
      exp_q.push_back(v(1,0,0,0,1,0,0,0, 2'd0, 2'd0, 4'd0, 3'd2));
      exp_q.push_back(v(0,0,0,1,0,0,1,0, 2'd0, 2'd0, 4'd0, 3'd2));
    end else if (op == 6'd40) begin
      exp_q.push_back(v(0,1,0,0,1,0,0,0, 2'd0, 2'd0, 4'd0, 3'd2));
    end else if (op == 6'd0) begin
      exp_q.push_back(v(0,0,1,0,0,0,0,0, 2'd0, 2'd0, 4'd0, ref_alu(f)));
      exp_q.push_back(v(0,0,0,0,0,0,1,1, 2'd0, 2'd0, 4'd0, 3'd2));
    end else if (op == 6'd4) begin
      exp_q.push_back(v(0,0,1,0,0,z,0,0, 2'd1, 2'd0, 4'd0, 3'd6));
    end else if (op == 6'd2) begin
      exp_q.push_back(v(0,0,0,0,0,1,0,0, 2'd2, 2'd0, 4'd0, 3'd2));
    end
  endtask

  task automatic test_reset();
    logic [6:0] wr;
    repeat (3) begin
      @(posedge clk); @(negedge clk); #1;
      wr = {bus.memread, bus.memwrite, bus.regwrite, bus.pcen, bus.irwrite};
      total++;
      if (wr !== 7'd0) begin bad++; $display("FAIL reset_gate got=%b exp=0", wr); end
    end
    reset = 1'b0; #1;
    total++;
    if ({bus.memread, bus.irwrite, bus.pcen} !== 6'b1_0001_1) begin
      bad++; $display("FAIL reset_release got=%b exp=100011", {bus.memread, bus.irwrite, bus.pcen});
    end
  endtask

  task automatic test_lb();
    model(6'b100000, 6'd0, 1'b0);
    bus.op = 6'b100000; bus.funct = 6'd0; bus.zero = 1'b0;
    total++;
    if (exp_q.size() != 8) begin bad++; $display("FAIL lb_len got=%0d exp=8", exp_q.size()); end
    foreach (exp_q[i]) begin
      #1; total++;
      if (obs() !== exp_q[i]) begin bad++; $display("FAIL lb cyc%0d got=%h exp=%h", i, obs(), exp_q[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_rtype_slt();
    model(6'd0, 6'b101010, 1'b0);
    bus.op = 6'd0; bus.funct = 6'b101010; bus.zero = 1'b1;
    foreach (exp_q[i]) begin
      #1; total++;
      if (obs() !== exp_q[i]) begin bad++; $display("FAIL rtype cyc%0d got=%h exp=%h", i, obs(), exp_q[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_beq(input bit z);
    model(6'b000100, 6'd0, z);
    bus.op = 6'b000100; bus.funct = 6'd0; bus.zero = z;
    foreach (exp_q[i]) begin
      #1; total++;
      if (obs() !== exp_q[i]) begin bad++; $display("FAIL beq_z%0d cyc%0d got=%h exp=%h", z, i, obs(), exp_q[i]); end
      @(negedge clk);
    end
  endtask

  task automatic test_illegal();
    model(6'b111111, 6'd0, 1'b0);
    bus.op = 6'b111111; bus.funct = 6'd0; bus.zero = 1'b0;
    foreach (exp_q[i]) begin
      #1; total++;
      if (obs() !== exp_q[i]) begin bad++; $display("FAIL illegal cyc%0d got=%h exp=%h", i, obs(), exp_q[i]); end
      @(negedge clk);
    end
    #1; total++;
    if ({bus.irwrite, bus.alusrcb} !== 6'b0001_01) begin
      bad++; $display("FAIL illegal_ret got=%b exp=000101", {bus.irwrite, bus.alusrcb});
    end
  endtask

  task automatic test_sb_reset();
    bit seen_mw;
    seen_mw = 1'b0;
    model(6'b101000, 6'd0, 1'b0);
    bus.op = 6'b101000; bus.funct = 6'd0; bus.zero = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #1; total++;
      if (bus.memwrite) seen_mw = 1'b1;
      if (obs() !== exp_q[i]) begin bad++; $display("FAIL sb cyc%0d got=%h exp=%h", i, obs(), exp_q[i]); end
      if (i == 5) reset = 1'b1;
      @(negedge clk);
    end
    #1; total++;
    if (bus.memwrite) seen_mw = 1'b1;
    if ({bus.memread, bus.memwrite, bus.alusrca, bus.alusrcb} !== 5'b000_01) begin
      bad++; $display("FAIL sb_reset_state got=%b exp=00001", {bus.memread, bus.memwrite, bus.alusrca, bus.alusrcb});
    end
    reset = 1'b0; #1;
    total++;
    if ({bus.memread, bus.irwrite, bus.pcen} !== 6'b1_0001_1) begin
      bad++; $display("FAIL sb_refetch got=%b exp=100011", {bus.memread, bus.irwrite, bus.pcen});
    end
    total++;
    if (seen_mw) begin bad++; $display("FAIL sb_memwrite got=1 exp=0"); end
  endtask

  task automatic test_random();
    logic [5:0] ops[5] = '{6'd32, 6'd40, 6'd0, 6'd4, 6'd2};
    logic [5:0] fns[5] = '{6'd32, 6'd34, 6'd36, 6'd37, 6'd42};
    logic [5:0] op, f;
    bit z;
    for (int n = 0; n < 40; n++) begin
      op = ($urandom_range(0, 5) == 5) ? 6'($urandom) : ops[$urandom_range(0, 4)];
      f  = ($urandom_range(0, 3) == 0) ? 6'($urandom) : fns[$urandom_range(0, 4)];
      z  = 1'($urandom);
      model(op, f, z);
      bus.op = op; bus.funct = f; bus.zero = z;
      foreach (exp_q[i]) begin
        #1; total++;
        if (obs() !== exp_q[i]) begin
          bad++; $display("FAIL rand n%0d op=%b cyc%0d got=%h exp=%h", n, op, i, obs(), exp_q[i]);
        end
        @(negedge clk);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.op = 6'd0; bus.funct = 6'd0; bus.zero = 1'b0;
    test_reset();
    test_lb();
    test_rtype_slt();
    test_beq(1'b1);
    test_beq(1'b0);
    test_illegal();
    test_sb_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mips_controller.md
# mips_controller

Multicycle control unit for the 8-bit MIPS datapath: a Moore state machine that sequences the four byte-wide instruction fetches, decodes the opcode and drives every datapath enable and mux select. It also contains the ALU decoder and forms the PC enable from the branch and zero terms. This block generates the control words that the datapath gates (including `and2`) combine and consume.

## Interface
Parameters: none. All widths are fixed by the 8-bit datapath.

Ports:
- `clk`  in  1  single clock; all state updates occur on the rising edge.
- `reset`  in  1  synchronous, active-high.
- `op`  in  6  opcode, `instr[31:26]`, from the instruction register.
- `funct`  in  6  function field, `instr[5:0]`.
- `zero`  in  1  ALU zero flag.
- `memread`  out  1  memory read strobe.
- `memwrite`  out  1  memory write strobe.
- `alusrca`  out  1  ALU A source: 0 = PC, 1 = register A.
- `memtoreg`  out  1  register-file write data: 0 = ALUOut, 1 = MDR.
- `iord`  out  1  memory address: 0 = PC, 1 = ALUOut.
- `pcen`  out  1  PC load enable.
- `regwrite`  out  1  register-file write enable.
- `regdst`  out  1  write register: 0 = rt, 1 = rd.
- `pcsource`  out  2  next PC: 00 = ALU result, 01 = ALUOut, 10 = jump target.
- `alusrcb`  out  2  ALU B source: 00 = B, 01 = constant 1, 10 = imm, 11 = imm<<2.
- `irwrite`  out  4  one-hot byte enable for instruction-register bytes 0..3.
- `alucontrol`  out  3  ALU operation.

## Operation
- Opcodes: LB = 100000, SB = 101000, RTYPE = 000000, BEQ = 000100, J = 000010.
- Unless a state below lists otherwise, every output is 0 in that state.
- States and their nonzero outputs:
  - FETCH1: memread, irwrite = 0001, alusrcb = 01, pcwrite. Next: FETCH2.
  - FETCH2: same as FETCH1 but irwrite = 0010. Next: FETCH3.
  - FETCH3: same as FETCH1 but irwrite = 0100. Next: FETCH4.
  - FETCH4: same as FETCH1 but irwrite = 1000. Next: DECODE.
  - DECODE: alusrcb = 11. Next depends on op: LB or SB → MEMADR; RTYPE → RTYPEEX; BEQ → BEQEX; J → JEX; any other op → FETCH1 (illegal opcode, no architectural effect).
  - MEMADR: alusrca, alusrcb = 10. Next: LBRD if op = LB, else SBWR.
  - LBRD: memread, iord. Next: LBWR.
  - LBWR: regwrite, memtoreg. Next: FETCH1.
  - SBWR: memwrite, iord. Next: FETCH1.
  - RTYPEEX: alusrca, aluop = 10. Next: RTYPEWR.
  - RTYPEWR: regdst, regwrite. Next: FETCH1.
  - BEQEX: alusrca, aluop = 01, branch, pcsource = 01. Next: FETCH1.
  - JEX: pcwrite, pcsource = 10. Next: FETCH1.
- `pcen` = pcwrite | (branch & zero).
- ALU decoder:
  - aluop 00 → 010 (add); aluop 01 → 110 (sub).
  - aluop 10 decodes funct: 100000 → 010, 100010 → 110, 100100 → 000, 100101 → 001, 101010 → 111; any other funct → 101.
  - aluop 11 is unused and decodes as 010.
- Unused state encodings go to FETCH1 on the next edge and drive all outputs to 0.

## Timing
- All outputs are Moore outputs decoded from the state register, except `pcen` (depends combinationally on `zero`) and `alucontrol` (depends combinationally on `funct`).
- Reset:
  - `reset` high at an edge puts the state in FETCH1. This applies in any state, including mid-instruction; the partial instruction is abandoned and nothing further is written.
  - While `reset` is high, memread, memwrite, regwrite, pcen and irwrite are forced to 0 regardless of state.
  - The first fetch strobe appears in the cycle after `reset` falls.
- Cycles per instruction: LB 8, SB 7, RTYPE 7, BEQ 6, J 6, illegal 5.
- `op` and `funct` are sampled only in DECODE, MEMADR and RTYPEEX, and must be stable in those cycles.

## Structure
- Package `mips_ctrl_pkg` holds:
  - the state enum (4-bit encoding);
  - opcode and funct constants;
  - alucontrol codes;
  - the pcsource and alusrcb encodings.
- Sub-module `mips_aludec`: inputs aluop[1:0] and funct[5:0], output alucontrol[2:0]; purely combinational.
- `mips_controller` holds the state register, next-state logic, output decode and pcen.

## Test plan
- Reset held for 3 cycles, then released → one cycle later the state is FETCH1 with memread = 1, irwrite = 0001, pcen = 1; during reset all write enables are 0.
- op = 100000 (LB) → 8-cycle sequence; LBWR asserts regwrite = 1, memtoreg = 1; return to FETCH1.
- op = 000000, funct = 101010 (RTYPE slt) → RTYPEEX shows alucontrol = 111, alusrca = 1; RTYPEWR shows regdst = 1, regwrite = 1.
- op = 000100 (BEQ):
  - zero = 1 → in BEQEX, pcen = 1 and pcsource = 01.
  - zero = 0 → pcen = 0.
- op = 111111 → DECODE is followed by FETCH1 (5 cycles total); no memwrite or regwrite is asserted.
- op = 101000 (SB) with reset pulsed in MEMADR → next state is FETCH1 and memwrite is never asserted.
